// File: rtl/mul16_seq_if.sv
// Handshake/data bundle for the sequential 16x16 multiplier.
// The master issues operands and start; the slave returns the product and status.
interface mul16_seq_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] P;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output A,
    output B,
    input  P,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output P,
    output busy,
    output done
  );
endinterface

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-add multiplier built around a 16-bit ripple adder.
// One partial product is accumulated per clock; a one-cycle done pulse marks a new product.

// 16-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  logic [16:0] carry;

  assign carry[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_fa
      assign Sum[gi]     = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign Cout = carry[16];
endmodule

module mul16_seq #(
  parameter int N = 16  // operand width; only 16 is supported since add16 is fixed-width
) (
  input logic          clk,
  input logic          rst,
  mul16_seq_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [N-1:0]     m_reg;      // latched multiplicand
  logic [N-1:0]     h_reg;      // upper half of the running accumulator
  logic [N-1:0]     q_reg;      // multiplier, shifting out as product low bits shift in
  logic [3:0]       count_reg;  // iteration index 0..15
  logic [2*N-1:0]   p_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             cout;
  logic [2*N-1:0]   next_hq;

  // Partial product for this iteration: multiplicand gated by the current multiplier LSB.
  assign addend = q_reg[0] ? m_reg : '0;

  add16 u_add16 (
    .A    (h_reg),
    .B    (addend),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // {Cout,Sum,Q} shifted right by one; keeping Cout is what makes 0xFFFF*0xFFFF exact.
  assign next_hq = {cout, sum, q_reg[N-1:1]};

  // Control FSM and datapath registers; rst abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= '0;
      h_reg     <= '0;
      q_reg     <= '0;
      count_reg <= '0;
      p_reg     <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            m_reg     <= bus.A;
            q_reg     <= bus.B;
            h_reg     <= '0;
            count_reg <= '0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end
        RUN: begin
          h_reg     <= next_hq[2*N-1:N];
          q_reg     <= next_hq[N-1:0];
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            p_reg     <= next_hq;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.P    = p_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: a cycle model of the start/busy/done protocol plus a
// scoreboard of products pushed on accepted starts and popped on done.
module tb_mul16_seq;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul16_seq_if bus ();

  mul16_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          n_assert  = 0;
  int          n_fail    = 0;
  int          phase     = 0;   // 0 idle, 1..16 run cycles, 17 done cycle
  logic [31:0] p_model   = '0;
  logic [31:0] sb[$];
  int          cyc       = 0;
  int          last_done = -1;
  int          done_gap  = 0;
  int          n_done    = 0;   // dones seen on the DUT
  int          n_busy    = 0;   // cycles the DUT reported busy

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock, step the reference model, and compare all outputs.
  task automatic tick();
    logic        r, s;
    logic [15:0] a, b;
    r = rst;
    s = bus.start;
    a = bus.A;
    b = bus.B;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      phase   = 0;
      p_model = '0;
      sb.delete();
    end else if (phase == 0) begin
      if (s) begin
        phase = 1;
        sb.push_back(32'(a) * 32'(b));
      end
    end else if (phase == 17) begin
      phase = 0;
    end else begin
      phase++;
    end
    if (phase == 17) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) p_model = sb.pop_front();
    end
    if (bus.done === 1'b1) begin
      if (last_done >= 0) done_gap = cyc - last_done;
      last_done = cyc;
      n_done++;
    end
    if (bus.busy === 1'b1) n_busy++;
    chk("busy", 32'(bus.busy), 32'(phase != 0));
    chk("done", 32'(bus.done), 32'(phase == 17));
    chk("P", bus.P, p_model);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (phase != 0 && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle(40);
    chk("result", bus.P, exp);
    repeat (5) tick();  // P must hold after completion
  endtask

  initial begin
    int d0, b0, k;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();

    // Basic product with busy-length check
    b0 = n_busy;
    d0 = n_done;
    run_op(16'd3, 16'd5, 32'h0000000F);
    chk("busy_cycles", 32'(n_busy - b0), 32'd17);
    chk("done_count", 32'(n_done - d0), 32'd1);

    // Carry path and shifted operands
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_op(16'hABCD, 16'h0100, 32'h00ABCD00);

    // Zero operands
    run_op(16'h1234, 16'h0000, 32'h00000000);
    run_op(16'h0000, 16'hFFFF, 32'h00000000);

    // Start re-pulsed and operands changed mid-run must be ignored
    d0        = n_done;
    bus.A     = 16'd7;
    bus.B     = 16'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    bus.start = 1'b1;
    bus.A     = 16'd100;
    bus.B     = 16'd100;
    tick();
    bus.start = 1'b0;
    bus.A     = 16'd0;
    bus.B     = 16'd0;
    wait_idle(40);
    chk("ignored_start_P", bus.P, 32'd63);
    chk("ignored_start_dones", 32'(n_done - d0), 32'd1);
    repeat (3) tick();

    // Held-high start gives back-to-back results 18 cycles apart
    d0        = n_done;
    bus.A     = 16'd11;
    bus.B     = 16'd13;
    bus.start = 1'b1;
    k         = 0;
    while (n_done < d0 + 2 && k < 80) begin
      tick();
      k++;
    end
    bus.start = 1'b0;
    chk("held_dones", 32'(n_done - d0), 32'd2);
    chk("held_spacing", 32'(done_gap), 32'd18);
    chk("held_P", bus.P, 32'd143);
    wait_idle(40);
    repeat (3) tick();

    // Reset during RUN abandons the operation
    d0        = n_done;
    bus.A     = 16'h00FF;
    bus.B     = 16'h00FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_P", bus.P, 32'd0);
    repeat (20) tick();
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    run_op(16'd2, 16'd2, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
